pet2001tape_play: RTL
=====================

Name: pet2001tape_play

Overview:
- Cassette playback engine for the PET core: turns a stream of C64-style TAP bytes into the `cass_read` pulse train seen by the cassette-read input of the I/O block.
- Also drives `cass_sense_n` (PLAY key).
- Obeys `cass_motor_n` from the PIA.
- Sits between the tape-image byte source (SD/OSD loader, with a FIFO upstream) and the I/O block.
- Timing is counted in CPU cycles using the 1 MHz clock enable.

Parameters:
- TAP_SCALE, 8: CPU cycles per unit of a non-zero TAP byte.
- CNT_W, 24: width of the pulse-length counter, in cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ce_1m  input  1  one-clk enable per CPU cycle; the only tick that advances timing
- play  input  1  level; 1 = PLAY key held (tape running)
- tap_version  input  1  0 = TAP v0 zero-byte rule, 1 = TAP v1 zero-byte rule
- tap_data  input  8  next image byte (header already stripped upstream)
- tap_valid  input  1  tap_data is valid
- tap_rd  output  1  one-clk strobe; byte consumed this clk
- cass_motor_n  input  1  0 = motor on
- cass_sense_n  output  1  0 = PLAY pressed
- cass_read  output  1  tape read signal to the I/O block
- busy  output  1  1 = pulse in progress or extended length being collected

Behaviour:
- One clock domain; reset is synchronous and active-high. Clock port is `clk`, reset port is `reset`.
- Reset values:
  - state = IDLE
  - cass_read = 1
  - tap_rd = 0
  - busy = 0
  - cass_sense_n = 1
  - counter = 0
- `cass_sense_n` = ~play, registered (1 clk latency).
- `run` = play && !cass_motor_n && ce_1m. The counter decrements only on `run`. With motor off, the state and cass_read are frozen mid-pulse (pause, not reset).
- States: IDLE, FETCH, EXT0, EXT1, EXT2, LOW, HIGH.
- IDLE:
  - cass_read = 1.
  - Goes to FETCH when play = 1.
- FETCH:
  - When tap_valid = 1 and cass_motor_n = 0, assert tap_rd for that clk and latch tap_data.
  - tap_data ≠ 0: len = tap_data × TAP_SCALE; go to LOW.
  - tap_data = 0 and tap_version = 0: len = 256 × TAP_SCALE; go to LOW.
  - tap_data = 0 and tap_version = 1: go to EXT0.
  - When tap_valid = 0 (underflow): wait in FETCH with cass_read = 1. This is not an error.
- EXT0/EXT1/EXT2:
  - Each accepts one byte with the same tap_valid/tap_rd handshake.
  - The bytes form len[7:0], then len[15:8], then len[23:16] (little-endian).
  - EXT2 then goes to LOW. If len = 0, it goes to FETCH with no pulse.
- LOW:
  - cass_read falls on the clk after the byte that completes len is consumed.
  - Low phase lasts lo = ceil(len/2) run ticks; then go to HIGH.
- HIGH:
  - cass_read = 1 for hi = len − lo run ticks; then go to FETCH.
  - If hi = 0, go straight to FETCH.
- Pulse period is exactly len run ticks, with a single falling edge per pulse.
- At most one tap_rd per clk. tap_rd is never asserted unless tap_valid = 1 in the same clk.
- busy = 1 in EXT0..2, LOW and HIGH.
- play → 0 in any state: next clk state = IDLE, cass_read = 1, any partial extended length is discarded, no further tap_rd.
- reset mid-pulse: same as the reset values. Bytes already consumed are not replayed.
- Counter arithmetic is unsigned CNT_W bits. Length products use CNT_W bits; the maximum non-extended length is 2048, which fits.
- When run occurs in the same clk as a state transition, the tick is applied to the new phase's counter load, not lost: the load value is already reduced by 1.

Test Plan:
- play = 1, motor on, TAP byte 0x10: tap_rd once; cass_read low for 64 ce_1m ticks, then high for 64; next tap_rd when the HIGH phase ends.
- tap_version = 0, byte 0x00: 2048-tick pulse (1024 low / 1024 high). tap_version = 1, bytes 00 40 0D 03: four tap_rd strobes; 200000-tick pulse (100000 low / 100000 high).
- Motor off (cass_motor_n = 1) at tick 20 of a 64-tick low phase, held for 500 ticks, then motor on: cass_read stays 0; the remaining 44 low ticks resume; no tap_rd while paused.
- tap_valid = 0 in FETCH for 300 ticks: cass_read = 1, tap_rd = 0, busy = 0. When valid returns with 0x01: 8-tick pulse (4 low / 4 high).
- play dropped during EXT1 of a v1 sequence: next clk IDLE, cass_read = 1, cass_sense_n = 1 one clk later. Replay then starts from the next byte as a fresh code.
- v1 extended length 00 00 00: three extension bytes consumed, no falling edge, immediate return to FETCH. Also check odd length 0x0F×8 = 120 → 60 low / 60 high, and len = 1 → 1 low / 0 high.

Source files
------------

// File: rtl/pet2001tape_play.sv
// rtl/pet2001tape_play.sv - TAP byte stream to PET cassette-read pulse train
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   ce_1m          one-clk enable per CPU cycle; all pulse timing counts these
//   play           PLAY key level; dropping it aborts playback immediately
//   tap_version    0 = zero byte is a 256-unit pulse, 1 = zero byte opens a 24-bit length
//   tap_data/tap_valid/tap_rd  byte source handshake; tap_rd strobes on consumption
//   cass_motor_n   PIA motor control, 0 = motor on; off pauses the pulse in place
//   cass_sense_n   registered ~play
//   cass_read      tape read line, low for the first half of each pulse
//   busy           extended length being collected or pulse in progress

module pet2001tape_play #(
    parameter int TAP_SCALE = 8,
    parameter int CNT_W     = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_1m,
    input  logic       play,
    input  logic       tap_version,
    input  logic [7:0] tap_data,
    input  logic       tap_valid,
    output logic       tap_rd,
    input  logic       cass_motor_n,
    output logic       cass_sense_n,
    output logic       cass_read,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, FETCH, EXT0, EXT1, EXT2, LOW, HIGH} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   len_q, len_nxt;
    logic               active, run, take, phase_done;
    logic [CNT_W-1:0]   run_w, byte_len, zero_len, ext_len, hi_len;
    logic [23:0]        ext_raw;

    // Low half gets the odd tick so the falling edge sits at the pulse start.
    function automatic logic [CNT_W-1:0] lo_of(input logic [CNT_W-1:0] l);
        return (l >> 1) + CNT_W'(l[0]);
    endfunction

    assign active   = play & ~cass_motor_n;
    assign run      = active & ce_1m;
    assign run_w    = CNT_W'(run);
    assign byte_len = CNT_W'(tap_data) * CNT_W'(TAP_SCALE);
    assign zero_len = CNT_W'(256 * TAP_SCALE);
    assign ext_raw  = {tap_data, len_q[15:0]};
    assign ext_len  = CNT_W'(ext_raw);
    assign hi_len   = len_q >> 1;

    assign take   = !reset && active && tap_valid &&
                    (state inside {FETCH, EXT0, EXT1, EXT2});
    assign tap_rd = take;
    assign busy   = state inside {EXT0, EXT1, EXT2, LOW, HIGH};

    // A phase ends either on the tick that exhausts it, or immediately when it
    // was entered already satisfied (load of 0 after a same-clk tick credit).
    assign phase_done = active && ((cnt == '0) || (run && (cnt == CNT_W'(1))));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        case (state)
            IDLE: begin
                if (play) state_nxt = FETCH;
            end
            FETCH: begin
                if (take) begin
                    if (tap_data != 8'd0) begin
                        len_nxt   = byte_len;
                        cnt_nxt   = lo_of(byte_len) - run_w;
                        state_nxt = LOW;
                    end else if (!tap_version) begin
                        len_nxt   = zero_len;
                        cnt_nxt   = lo_of(zero_len) - run_w;
                        state_nxt = LOW;
                    end else begin
                        len_nxt   = '0;
                        state_nxt = EXT0;
                    end
                end
            end
            EXT0: begin
                if (take) begin
                    len_nxt   = CNT_W'(tap_data);
                    state_nxt = EXT1;
                end
            end
            EXT1: begin
                if (take) begin
                    len_nxt[15:8] = tap_data;
                    state_nxt     = EXT2;
                end
            end
            EXT2: begin
                if (take) begin
                    if (ext_len == '0) begin
                        len_nxt   = '0;
                        state_nxt = FETCH;
                    end else begin
                        len_nxt   = ext_len;
                        cnt_nxt   = lo_of(ext_len) - run_w;
                        state_nxt = LOW;
                    end
                end
            end
            LOW: begin
                if (phase_done) begin
                    if (hi_len == '0) begin
                        cnt_nxt   = '0;
                        state_nxt = FETCH;
                    end else begin
                        // A tick landing on an already-empty phase belongs to HIGH.
                        cnt_nxt   = hi_len - ((cnt == '0) ? run_w : '0);
                        state_nxt = HIGH;
                    end
                end else if (run) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HIGH: begin
                if (phase_done) begin
                    cnt_nxt   = '0;
                    state_nxt = FETCH;
                end else if (run) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!play) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            len_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            len_q        <= '0;
            cass_read    <= 1'b1;
            cass_sense_n <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            len_q        <= len_nxt;
            cass_read    <= (state_nxt != LOW);
            cass_sense_n <= ~play;
        end
    end

endmodule
